// File: rtl/f1_pkg.sv
// Shared types and constants for the race-start sequencer.
package f1_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LIGHT_UP,
    HOLD,
    MEASURE,
    DONE,
    SYNC
  } state_t;

  localparam logic [7:0] LIGHTS_FULL = 8'hFF;
  localparam logic [7:0] LIGHTS_OFF  = 8'h00;

  localparam int LFSR_W      = 7;
  localparam int LFSR_TAP_HI = 6;
  localparam int LFSR_TAP_LO = 2;

  // x^7 + x^3 + 1: maximal length, so a non-zero seed never reaches zero.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
  endfunction

endpackage

// File: rtl/f1_tick_gen.sv
// Light-step pacing: counts 0..TICK_CYCLES-1, tick pulses on the terminal count.
// clr restarts the count; tick is suppressed while clr is high.
module f1_tick_gen #(
  parameter int TICK_CYCLES = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = ~clr & (cnt_q == LAST);

endmodule

// File: rtl/f1_start_ctrl.sv
// Race-start sequencer: paces the light FSM on, holds for a random number of ticks,
// switches lights out and measures reaction time; early presses flag a jump start.
module f1_start_ctrl
  import f1_pkg::*;
#(
  parameter int              TICK_CYCLES = 24,
  parameter logic [LFSR_W-1:0] LFSR_SEED = 7'h01,
  parameter int              RT_WIDTH    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                btn,
  input  logic [7:0]          fsm_lights,
  output logic                fsm_en,
  output logic                result_valid,
  output logic [RT_WIDTH-1:0] react_time,
  output logic                jump_start,
  output logic                busy
);

  state_t              state_q;
  logic                start_q, btn_q, clr_q;
  logic [LFSR_W-1:0]   lfsr_q, delay_q;
  logic [RT_WIDTH-1:0] cnt_q, react_q;
  logic                rv_q, js_q;
  logic                tick, start_e, btn_e, lights_full, lights_off;

  assign start_e     = start & ~start_q;
  assign btn_e       = btn & ~btn_q;
  assign lights_full = (fsm_lights == LIGHTS_FULL);
  assign lights_off  = (fsm_lights == LIGHTS_OFF);

  // clr_q is high for the first LIGHT_UP cycle, so the first step lands TICK_CYCLES later.
  f1_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_q),
    .tick (tick)
  );

  // A press always wins over a coincident step, so no light moves on a jump.
  always_comb begin
    fsm_en = 1'b0;
    case (state_q)
      LIGHT_UP: fsm_en = tick & ~btn_e & ~lights_full;
      HOLD:     fsm_en = tick & ~btn_e & (delay_q == LFSR_W'(1));
      SYNC:     fsm_en = ~lights_off;
      default:  fsm_en = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      btn_q   <= 1'b0;
      clr_q   <= 1'b0;
      lfsr_q  <= LFSR_SEED;
      delay_q <= '0;
      cnt_q   <= '0;
      react_q <= '0;
      rv_q    <= 1'b0;
      js_q    <= 1'b0;
    end else begin
      start_q <= start;
      btn_q   <= btn;
      lfsr_q  <= lfsr_next(lfsr_q);
      clr_q   <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start_e) begin
            rv_q <= 1'b0;
            js_q <= 1'b0;
            if (lights_off) begin
              state_q <= LIGHT_UP;
              clr_q   <= 1'b1;
            end else begin
              state_q <= SYNC;
            end
          end
        end
        LIGHT_UP: begin
          if (btn_e) begin
            js_q    <= 1'b1;
            state_q <= SYNC;
          end else if (lights_full) begin
            delay_q <= lfsr_q;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (btn_e) begin
            js_q    <= 1'b1;
            state_q <= SYNC;
          end else if (tick) begin
            if (delay_q == LFSR_W'(1)) begin
              // Counting the lights-out cycle as 1 makes a press k cycles later read k.
              cnt_q   <= RT_WIDTH'(1);
              state_q <= MEASURE;
            end else begin
              delay_q <= delay_q - LFSR_W'(1);
            end
          end
        end
        MEASURE: begin
          if (btn_e) begin
            react_q <= cnt_q;
            rv_q    <= 1'b1;
            state_q <= DONE;
          end else if (cnt_q != {RT_WIDTH{1'b1}}) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        SYNC: begin
          if (lights_off) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign result_valid = rv_q;
  assign react_time   = react_q;
  assign jump_start   = js_q;
  assign busy         = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_f1_start_ctrl.sv
// Bench for f1_start_ctrl: two instances (16-bit and 4-bit reaction counter) share stimulus;
// a light-FSM model closes the loop and a cycle-level timing model predicts every enable.
module tb_f1_start_ctrl;

  localparam int TC = 4;
  localparam int M_NORM = 0, M_HOLD = 1, M_LU = 2;
  localparam int F_SHELD = 1, F_BHELD = 2, F_SMEAS = 4;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, btn = 1'b0;
  logic [7:0] lights, lights2;
  logic en, en2, rv, rv2, js, js2, busy, busy2;
  logic [15:0] rt;
  logic [3:0]  rt2;
  int cyc, lvl, lvl2;
  int n_vec = 0, n_bad = 0;
  int last_rt = 0, last_rt4 = 0;

  typedef struct {
    int mode; int k; int flags;
    int exp_rv; int exp_js; int exp_rt; int exp_rt4;
  } rec_t;
  rec_t recs[$];

  always #5 clk = ~clk;

  f1_start_ctrl #(.TICK_CYCLES(TC), .LFSR_SEED(7'h01), .RT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .btn(btn), .fsm_lights(lights),
    .fsm_en(en), .result_valid(rv), .react_time(rt), .jump_start(js), .busy(busy));

  f1_start_ctrl #(.TICK_CYCLES(TC), .LFSR_SEED(7'h01), .RT_WIDTH(4)) u_sat (
    .clk(clk), .rst(rst), .start(start), .btn(btn), .fsm_lights(lights2),
    .fsm_en(en2), .result_valid(rv2), .react_time(rt2), .jump_start(js2), .busy(busy2));

  function automatic logic [7:0] therm(input int n);
    logic [8:0] t;
    t = (9'd1 << n) - 9'd1;
    return t[7:0];
  endfunction

  // Light FSM model: S0..S8, each enable advances one state, S8 wraps to S0.
  always @(posedge clk or posedge rst)
    if (rst) lvl <= 0; else if (en) lvl <= (lvl == 8) ? 0 : lvl + 1;
  always @(posedge clk or posedge rst)
    if (rst) lvl2 <= 0; else if (en2) lvl2 <= (lvl2 == 8) ? 0 : lvl2 + 1;
  assign lights  = therm(lvl);
  assign lights2 = therm(lvl2);

  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0; else cyc <= cyc + 1;

  function automatic int lfsr_at(input int n);
    logic [6:0] s;
    s = 7'h01;
    for (int i = 0; i < n; i++) s = {s[5:0], s[6] ^ s[2]};
    return int'(s);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_rec(input rec_t r, input int idx);
    int t0, d, e9, p, n, m, end_c, last, e_rt, e_rt4;
    int exp_en[$];
    int got_en[$];
    bit div;
    t0 = cyc;
    div = 1'b0;
    d  = lfsr_at(t0 + 2 + 8*TC);
    e9 = t0 + 1 + (8 + d)*TC;
    case (r.mode)
      M_NORM:  p = e9 + r.k;
      M_HOLD:  p = t0 + 1 + 8*TC + r.k;
      default: p = t0 + 1 + r.k;
    endcase
    if (r.mode != M_NORM && p > e9) p = e9;
    n = 0;
    for (int i = 1; i <= 8; i++)
      if (t0 + 1 + i*TC < p) begin exp_en.push_back(t0 + 1 + i*TC); n++; end
    if (p > e9) begin
      exp_en.push_back(e9);
      end_c = p + 1;
    end else begin
      m = (n == 0) ? 0 : 9 - n;
      for (int j = 1; j <= m; j++) exp_en.push_back(p + j);
      end_c = p + 2 + m;
    end
    last = end_c + 3*TC;

    for (int c = t0; c <= last; c++) begin
      start = (c == t0) || (((r.flags & F_SHELD) != 0) && c < last) ||
              (((r.flags & F_SMEAS) != 0) && c == e9 + 1 && p > e9 + 1);
      btn   = (((r.flags & F_BHELD) != 0) && c < e9) || (c >= p && c < p + 2);
      #1;
      if (en === 1'b1) got_en.push_back(c);
      if (en !== en2) div = 1'b1;
      if (c == t0 + 1) begin
        check($sformatf("r%0d_busy_run", idx), busy, 1);
        check($sformatf("r%0d_rv_clr", idx), rv, 0);
        check($sformatf("r%0d_js_clr", idx), js, 0);
      end
      @(negedge clk);
    end
    start = 1'b0;
    btn   = 1'b0;

    check($sformatf("r%0d_en_count", idx), got_en.size(), exp_en.size());
    for (int i = 0; i < got_en.size() && i < exp_en.size(); i++)
      check($sformatf("r%0d_en%0d_cycle", idx, i), got_en[i], exp_en[i]);
    check($sformatf("r%0d_en_sat_same", idx), {31'd0, div}, 0);

    e_rt  = (r.exp_rt  < 0) ? last_rt  : r.exp_rt;
    e_rt4 = (r.exp_rt4 < 0) ? last_rt4 : r.exp_rt4;
    check($sformatf("r%0d_busy_end", idx), busy, 0);
    check($sformatf("r%0d_lights_end", idx), lights, 0);
    check($sformatf("r%0d_result_valid", idx), rv, r.exp_rv);
    check($sformatf("r%0d_jump_start", idx), js, r.exp_js);
    check($sformatf("r%0d_react_time", idx), rt, e_rt);
    check($sformatf("r%0d_react_time_sat", idx), rt2, e_rt4);
    check($sformatf("r%0d_sat_flags", idx), {rv2, js2}, {r.exp_rv[0], r.exp_js[0]});
    last_rt  = e_rt;
    last_rt4 = e_rt4;
  endtask

  initial begin
    int md, kk;
    recs.push_back('{M_NORM, 37,     0,                 1, 0, 37, 15});
    recs.push_back('{M_HOLD, 5,      0,                 0, 1, -1, -1});
    recs.push_back('{M_NORM, 3,      F_SHELD,           1, 0, 3,  3});
    recs.push_back('{M_NORM, 25,     F_BHELD | F_SMEAS, 1, 0, 25, 15});
    recs.push_back('{M_LU,   2,      0,                 0, 1, -1, -1});
    recs.push_back('{M_LU,   3*TC,   0,                 0, 1, -1, -1});
    recs.push_back('{M_HOLD, 100000, 0,                 0, 1, -1, -1});
    recs.push_back('{M_NORM, 1,      0,                 1, 0, 1,  1});
    recs.push_back('{M_NORM, 20,     0,                 1, 0, 20, 15});
    for (int i = 0; i < 6; i++) begin
      md = int'($urandom_range(0, 2));
      if (md == M_NORM) begin
        kk = int'($urandom_range(1, 60));
        recs.push_back('{M_NORM, kk, 0, 1, 0, kk, (kk > 15) ? 15 : kk});
      end else if (md == M_HOLD) begin
        kk = int'($urandom_range(1, 300));
        recs.push_back('{M_HOLD, kk, 0, 0, 1, -1, -1});
      end else begin
        kk = int'($urandom_range(1, 8*TC + 1));
        recs.push_back('{M_LU, kk, 0, 0, 1, -1, -1});
      end
    end

    repeat (2) @(negedge clk);
    #1;
    check("reset_en", en, 0);
    check("reset_busy", busy, 0);
    check("reset_rv", rv, 0);
    check("reset_js", js, 0);
    check("reset_rt", rt, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < recs.size(); i++) run_rec(recs[i], i);

    // Reset in the middle of HOLD, then a clean sequence from lights off.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8*TC + 3) @(negedge clk);
    #1;
    check("hold_busy_before_rst", busy, 1);
    check("hold_lights_before_rst", lights, 8'hFF);
    rst = 1'b1;
    #1;
    check("rst_en", en, 0);
    check("rst_busy", busy, 0);
    check("rst_rv", rv, 0);
    check("rst_js", js, 0);
    check("rst_rt", rt, 0);
    check("rst_lights", lights, 0);
    @(negedge clk);
    rst = 1'b0;
    last_rt  = 0;
    last_rt4 = 0;
    run_rec('{M_NORM, 9, 0, 1, 0, 9, 9}, 99);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
